// File: rtl/mem_burst_initiator.sv
// mem_burst_initiator
// Burst master for a single-port memory with a valid/wr_rd/addr/wdata ->
// ready/rdata handshake. One accepted command (start address, beat count,
// direction) becomes one memory beat per word, with at most one beat
// outstanding at a time. Addresses wrap modulo DEPTH.
//
// Ports
//   clk, rst             : rising-edge clock, asynchronous active-high reset
//   cmd_valid/cmd_ready  : command handshake (ready only while idle)
//   cmd_wr/addr/len      : burst direction, start address, beat count 0..DEPTH
//   wr_data/_valid/_ready: write data stream, consumed on each issued write beat
//   rd_data/_valid       : read data stream, one strobe per word, no backpressure
//   busy, done, err      : burst in progress, end-of-burst pulse, timeout flag
//   mem_*                : request side towards the memory
//   mem_ready/mem_rdata  : memory response for the outstanding beat
module mem_burst_initiator #(
  parameter int WIDTH      = 16,
  parameter int DEPTH      = 64,
  parameter int ADDR_WIDTH = $clog2(DEPTH),
  parameter int TIMEOUT    = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_wr,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [ADDR_WIDTH:0]   cmd_len,
  input  logic [WIDTH-1:0]      wr_data,
  input  logic                  wr_data_valid,
  output logic                  wr_data_ready,
  output logic [WIDTH-1:0]      rd_data,
  output logic                  rd_data_valid,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic                  mem_valid,
  output logic                  mem_wr_rd,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [WIDTH-1:0]      mem_wdata,
  input  logic                  mem_ready,
  input  logic [WIDTH-1:0]      mem_rdata
);

  localparam int CNT_W = ADDR_WIDTH + 1;
  localparam int TO_W  = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic                  wr_q, wr_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [CNT_W-1:0]      len_q, len_d;
  logic [CNT_W-1:0]      issued_q, issued_d;
  logic [CNT_W-1:0]      completed_q, completed_d;
  logic                  outst_q, outst_d;
  logic [TO_W-1:0]       to_cnt_q, to_cnt_d;
  logic                  mem_valid_q, mem_valid_d;
  logic                  mem_wr_rd_q, mem_wr_rd_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [WIDTH-1:0]      mem_wdata_q, mem_wdata_d;
  logic [WIDTH-1:0]      rd_data_q, rd_data_d;
  logic                  rd_data_valid_q, rd_data_valid_d;
  logic                  done_q, done_d;
  logic                  err_q, err_d;
  logic                  busy_q, busy_d;

  logic                  complete_s;
  logic                  timeout_s;
  logic                  issue_s;
  logic [CNT_W-1:0]      completed_next_s;

  // Beat-level qualifiers shared by the next-state logic and the handshakes.
  always_comb begin
    complete_s = (state_q == S_RUN) && outst_q && mem_ready;
    // The waiting cycle that would be the TIMEOUT-th one aborts the burst.
    timeout_s  = (state_q == S_RUN) && outst_q && !mem_ready &&
                 (to_cnt_q == TO_W'(TIMEOUT - 1));
    // A new beat may be launched in the same cycle the previous one completes.
    issue_s    = (state_q == S_RUN) && !timeout_s && (issued_q < len_q) &&
                 (!outst_q || complete_s) && (!wr_q || wr_data_valid);
    completed_next_s = completed_q + {{(CNT_W-1){1'b0}}, complete_s};
  end

  assign cmd_ready     = (state_q == S_IDLE);
  assign wr_data_ready = issue_s && wr_q;

  // Next-state logic for the burst FSM, counters and registered outputs.
  always_comb begin
    state_d         = state_q;
    wr_d            = wr_q;
    addr_d          = addr_q;
    len_d           = len_q;
    issued_d        = issued_q;
    completed_d     = completed_q;
    outst_d         = outst_q;
    to_cnt_d        = to_cnt_q;
    mem_valid_d     = 1'b0;
    mem_wr_rd_d     = mem_wr_rd_q;
    mem_addr_d      = mem_addr_q;
    mem_wdata_d     = mem_wdata_q;
    rd_data_d       = rd_data_q;
    rd_data_valid_d = 1'b0;
    err_d           = err_q;

    case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          wr_d        = cmd_wr;
          addr_d      = cmd_addr;
          len_d       = cmd_len;
          issued_d    = {CNT_W{1'b0}};
          completed_d = {CNT_W{1'b0}};
          outst_d     = 1'b0;
          to_cnt_d    = {TO_W{1'b0}};
          err_d       = 1'b0;
          state_d     = (cmd_len == {CNT_W{1'b0}}) ? S_DONE : S_RUN;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RUN: begin
        if (complete_s) begin
          completed_d     = completed_next_s;
          outst_d         = 1'b0;
          to_cnt_d        = {TO_W{1'b0}};
          rd_data_valid_d = !wr_q;
          rd_data_d       = wr_q ? rd_data_q : mem_rdata;
        end else if (outst_q) begin
          to_cnt_d = to_cnt_q + {{(TO_W-1){1'b0}}, 1'b1};
        end else begin
          to_cnt_d = {TO_W{1'b0}};
        end

        if (issue_s) begin
          mem_valid_d = 1'b1;
          mem_addr_d  = addr_q;
          mem_wr_rd_d = wr_q;
          mem_wdata_d = wr_q ? wr_data : mem_wdata_q;
          outst_d     = 1'b1;
          to_cnt_d    = {TO_W{1'b0}};
          issued_d    = issued_q + {{(CNT_W-1){1'b0}}, 1'b1};
          addr_d      = (addr_q == ADDR_WIDTH'(DEPTH - 1)) ? {ADDR_WIDTH{1'b0}}
                                                           : addr_q + {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
        end else begin
          mem_valid_d = 1'b0;
        end

        if (timeout_s) begin
          outst_d = 1'b0;
          err_d   = 1'b1;
          state_d = S_DONE;
        end else if (completed_next_s == len_q) begin
          err_d   = 1'b0;
          state_d = S_DONE;
        end else begin
          state_d = S_RUN;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    done_d = (state_d == S_DONE);
    busy_d = (state_d != S_IDLE);
  end

  // State and output registers; reset abandons any burst without a done pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q         <= S_IDLE;
      wr_q            <= 1'b0;
      addr_q          <= {ADDR_WIDTH{1'b0}};
      len_q           <= {CNT_W{1'b0}};
      issued_q        <= {CNT_W{1'b0}};
      completed_q     <= {CNT_W{1'b0}};
      outst_q         <= 1'b0;
      to_cnt_q        <= {TO_W{1'b0}};
      mem_valid_q     <= 1'b0;
      mem_wr_rd_q     <= 1'b0;
      mem_addr_q      <= {ADDR_WIDTH{1'b0}};
      mem_wdata_q     <= {WIDTH{1'b0}};
      rd_data_q       <= {WIDTH{1'b0}};
      rd_data_valid_q <= 1'b0;
      done_q          <= 1'b0;
      err_q           <= 1'b0;
      busy_q          <= 1'b0;
    end else begin
      state_q         <= state_d;
      wr_q            <= wr_d;
      addr_q          <= addr_d;
      len_q           <= len_d;
      issued_q        <= issued_d;
      completed_q     <= completed_d;
      outst_q         <= outst_d;
      to_cnt_q        <= to_cnt_d;
      mem_valid_q     <= mem_valid_d;
      mem_wr_rd_q     <= mem_wr_rd_d;
      mem_addr_q      <= mem_addr_d;
      mem_wdata_q     <= mem_wdata_d;
      rd_data_q       <= rd_data_d;
      rd_data_valid_q <= rd_data_valid_d;
      done_q          <= done_d;
      err_q           <= err_d;
      busy_q          <= busy_d;
    end
  end

  assign mem_valid     = mem_valid_q;
  assign mem_wr_rd     = mem_wr_rd_q;
  assign mem_addr      = mem_addr_q;
  assign mem_wdata     = mem_wdata_q;
  assign rd_data       = rd_data_q;
  assign rd_data_valid = rd_data_valid_q;
  assign done          = done_q;
  assign err           = err_q;
  assign busy          = busy_q;

endmodule

// File: tb/tb_mem_burst_initiator.sv
// Self-checking bench for mem_burst_initiator: a behavioural memory responder
// with selectable latency, a reference memory image updated at burst level,
// directed scenarios and a batch of randomized bursts.
module tb_mem_burst_initiator;

  localparam int W  = 16;
  localparam int D  = 64;
  localparam int AW = 6;
  localparam int TO = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic          cmd_wr = 1'b0;
  logic [AW-1:0] cmd_addr = '0;
  logic [AW:0]   cmd_len = '0;
  logic [W-1:0]  wr_data = '0;
  logic          wr_data_valid = 1'b0;
  logic          wr_data_ready;
  logic [W-1:0]  rd_data;
  logic          rd_data_valid;
  logic          busy, done, err;
  logic          mem_valid, mem_wr_rd;
  logic [AW-1:0] mem_addr;
  logic [W-1:0]  mem_wdata;
  logic          mem_ready = 1'b0;
  logic [W-1:0]  mem_rdata = '0;

  mem_burst_initiator #(.WIDTH(W), .DEPTH(D), .ADDR_WIDTH(AW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_wr(cmd_wr),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .wr_data(wr_data), .wr_data_valid(wr_data_valid), .wr_data_ready(wr_data_ready),
    .rd_data(rd_data), .rd_data_valid(rd_data_valid),
    .busy(busy), .done(done), .err(err),
    .mem_valid(mem_valid), .mem_wr_rd(mem_wr_rd), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_ready(mem_ready), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // ---------------- memory environment ----------------
  logic [W-1:0]  marr    [D];   // physical memory contents seen by the DUT
  logic [W-1:0]  ref_mem [D];   // reference image, updated per completed burst
  bit            pend = 1'b0;
  int            dly = 0;
  logic [AW-1:0] paddr = '0;
  bit            mem_en = 1'b1;
  bit            stray = 1'b0;
  int            lat_max = 0;

  // Request side: a new beat appears while mem_valid is high; answer after
  // a random number of extra cycles (0 = ready in the request cycle).
  always @(negedge clk) begin
    if (rst) begin
      pend = 1'b0;
      dly = 0;
      mem_ready = 1'b0;
    end else begin
      if (mem_valid) begin
        pend  = 1'b1;
        paddr = mem_addr;
        dly   = (lat_max > 0) ? int'($urandom_range(0, lat_max)) : 0;
        if (mem_wr_rd) marr[mem_addr] = mem_wdata;
      end else if (pend && dly > 0) begin
        dly--;
      end
      mem_ready = (pend && dly == 0 && mem_en) || stray;
      mem_rdata = marr[paddr];
    end
  end

  // A beat is finished at the edge where mem_ready is seen high.
  always @(posedge clk) begin
    if (pend && mem_ready) pend = 1'b0;
  end

  // ---------------- burst driver / monitor ----------------
  int first_beat, last_beat, done_cyc;
  bit pat [7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};

  // stall: 0 = data always valid, 1 = random, 2 = fixed 1,0,0,1,1,0,1 pattern
  task automatic run_burst(input bit wr, input int addr, input int len,
                           input int stall, input int base, input bit exp_to);
    logic [W-1:0] wq[$];
    int idx = 0, beats = 0, rdn = 0, cyc = 1, pat_i = 0;
    bit done_seen = 0, prev_hs = 0;
    int exp_beats;
    for (int i = 0; i < len; i++) wq.push_back((base != 0) ? W'(base + i) : W'($urandom));
    first_beat = -1; last_beat = -1; done_cyc = -1;

    @(negedge clk);
    check_eq("idle_cmd_ready", cmd_ready, 1);
    check_eq("idle_busy", busy, 0);
    cmd_valid = 1'b1; cmd_wr = wr; cmd_addr = AW'(addr); cmd_len = (AW+1)'(len);
    wr_data_valid = 1'b0;
    @(negedge clk);
    cmd_valid = 1'b0;

    while (!done_seen && cyc < 600) begin
      if (wr) check_eq("wr_beat_follows_word", mem_valid, prev_hs);
      if (mem_valid) begin
        if (beats >= len) check_eq("extra_beat", 1, 0);
        else begin
          check_eq("beat_addr", mem_addr, (addr + beats) % D);
          check_eq("beat_dir", mem_wr_rd, wr);
          if (wr) check_eq("beat_wdata", mem_wdata, wq[beats]);
        end
        if (first_beat < 0) first_beat = cyc;
        last_beat = cyc;
        beats++;
      end
      if (rd_data_valid) begin
        if (wr || rdn >= len) check_eq("extra_rd_strobe", 1, 0);
        else check_eq("rd_data", rd_data, ref_mem[(addr + rdn) % D]);
        rdn++;
      end
      if (done) begin
        done_seen = 1;
        done_cyc = cyc;
        check_eq("done_err", err, exp_to);
        check_eq("done_busy", busy, 1);
      end
      prev_hs = 0;
      if (wr && idx < len && !done_seen) begin
        wr_data = wq[idx];
        case (stall)
          0: wr_data_valid = 1'b1;
          1: wr_data_valid = 1'($urandom_range(0, 1));
          default: begin wr_data_valid = pat[pat_i % 7]; pat_i++; end
        endcase
        #1;
        if (wr_data_ready) begin prev_hs = 1; idx++; end
      end else begin
        wr_data_valid = 1'b0;
      end
      @(negedge clk);
      cyc++;
    end
    wr_data_valid = 1'b0;

    check_eq("done_seen", done_seen, 1);
    exp_beats = exp_to ? 1 : len;
    check_eq("beat_count", beats, exp_beats);
    if (!wr) check_eq("rd_count", rdn, exp_to ? 0 : len);
    if (wr) begin
      check_eq("words_consumed", idx, len);
      for (int i = 0; i < len; i++) ref_mem[(addr + i) % D] = wq[i];
    end
    // cycle after the done pulse: back in idle, err held
    check_eq("done_one_cycle", done, 0);
    check_eq("post_cmd_ready", cmd_ready, 1);
    check_eq("post_busy", busy, 0);
    check_eq("err_held", err, exp_to);
  endtask

  initial begin
    for (int i = 0; i < D; i++) begin marr[i] = '0; ref_mem[i] = '0; end

    // reset state
    #1;
    check_eq("rst_busy", busy, 0);
    check_eq("rst_done", done, 0);
    check_eq("rst_err", err, 0);
    check_eq("rst_mem_valid", mem_valid, 0);
    check_eq("rst_rd_valid", rd_data_valid, 0);
    check_eq("rst_mem_addr", mem_addr, 0);
    check_eq("rst_cmd_ready", cmd_ready, 1);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // write burst with 1-cycle memory: back-to-back beats, done right after
    lat_max = 0;
    run_burst(1, 5, 4, 0, 16'hA000, 0);
    check_eq("wr_back_to_back", last_beat - first_beat, 3);
    check_eq("wr_done_latency", done_cyc - last_beat, 1);

    // read-back of the same words
    run_burst(0, 5, 4, 0, 0, 0);

    // wrap-around and empty burst
    run_burst(1, 62, 4, 0, 0, 0);
    run_burst(0, 62, 4, 0, 0, 0);
    run_burst(1, 10, 0, 0, 0, 0);

    // write-data stall pattern, then verify contents
    run_burst(1, 20, 4, 2, 0, 0);
    run_burst(0, 20, 4, 0, 0, 0);

    // timeout: memory never answers
    mem_en = 1'b0;
    run_burst(0, 30, 3, 0, 0, 1);
    check_eq("timeout_latency", done_cyc - first_beat, TO);
    // stray mem_ready while idle must be ignored
    stray = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_eq("stray_busy", busy | done | mem_valid | rd_data_valid, 0);
    end
    stray = 1'b0;
    mem_en = 1'b1;

    // reset in the middle of a write burst
    lat_max = 3;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_wr = 1'b1; cmd_addr = AW'(40); cmd_len = (AW+1)'(8);
    wr_data = 16'h5555; wr_data_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    repeat (4) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check_eq("midrst_busy", busy, 0);
    check_eq("midrst_mem_valid", mem_valid, 0);
    check_eq("midrst_cmd_ready", cmd_ready, 1);
    wr_data_valid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check_eq("midrst_no_done", done, 0);
    end
    rst = 1'b0;
    run_burst(1, 40, 8, 0, 0, 0);
    run_burst(0, 40, 8, 0, 0, 0);

    // randomized bursts against the reference image
    for (int n = 0; n < 14; n++) begin
      lat_max = $urandom_range(0, 3);
      run_burst(1'($urandom_range(0, 1)), $urandom_range(0, D - 1),
                $urandom_range(0, 12), 1, 0, 0);
    end
    lat_max = 2;
    run_burst(1, 0, D, 1, 0, 0);
    run_burst(0, 17, D, 0, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
